// File: rtl/bcd_serial_adder.sv
// Purpose : multi-digit packed-BCD adder, one decimal digit per clock, LSD first.
// Latency : start sampled at edge T -> busy cycles T+1..T+DIGITS -> done pulse in cycle T+DIGITS+1.
// Backpr. : none queued; start is ignored unless IDLE, and caller must wait for done.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, only honoured in IDLE
//   a, b, cin         packed-BCD operands (digit 0 in [3:0]) and carry into digit 0
//   busy              high while digits are being processed
//   done              one-cycle pulse when sum/cout/invalid are final
//   sum, cout         packed-BCD result and carry out of the top digit
//   invalid           some operand digit was >9 in the current operation (sticky)
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            invalid_q;
  logic            busy_q;
  logic            done_q;

  // Current digit pair selected by idx_q.
  logic [3:0]      a_dig;
  logic [3:0]      b_dig;
  logic [4:0]      s5;
  logic [3:0]      dig_d;
  logic            carry_d;
  logic            bad_dig;
  logic [W-1:0]    sum_d;

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  // Single-digit BCD add with +6 correction. Non-decimal inputs go through
  // the same rule (s up to 31); they only raise the invalid flag.
  always_comb begin
    s5      = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
    bad_dig = (a_dig > 4'd9) || (b_dig > 4'd9);
    if (s5 > 5'd9) begin
      dig_d   = s5[3:0] + 4'd6;
      carry_d = 1'b1;
    end else begin
      dig_d   = s5[3:0];
      carry_d = 1'b0;
    end
  end

  // Drop the new digit into its slot; untouched digits keep their value
  // (still zero for digits not yet processed).
  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sum_d[4*i +: 4] = dig_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            carry_q   <= cin;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ADD;
          end
        end

        S_ADD: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          if (bad_dig) begin
            invalid_q <= 1'b1;
          end
          if (idx_q == IW'(DIGITS - 1)) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end

        S_DONE: begin
          // start seen here is deliberately dropped.
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Purpose : directed self-checking bench for bcd_serial_adder with DIGITS=4.
// Latency : checks exact busy/done cycle positions around every operation.
// Backpr. : exercises start while busy / in DONE, and reset mid-operation.
module tb_bcd_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int checks;
  int failures;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle, sampling point 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation started in the current cycle. Optional extras:
  // scramble inputs while busy, re-assert start while busy and in DONE,
  // and check the partial sum each busy cycle (ps[15:0] = first busy cycle).
  task automatic do_op(input string tag,
                       input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       input logic [15:0] es, input logic ec, input logic ei,
                       input bit scramble, input bit restart,
                       input bit partial, input logic [63:0] ps);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".done_early"}, 32'(done), 32'd0);
      if (partial) check({tag, ".partial"}, 32'(sum), 32'(ps[16*(k-1) +: 16]));
      if (scramble) begin
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
      end
      if (restart) begin
        a     = 16'h1111;
        b     = 16'h1111;
        start = (k == 2);
      end
      step();
    end
    // Start held during the DONE cycle must be dropped.
    start = restart;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".invalid"}, 32'(invalid), 32'(ei));
    step();
    start = 1'b0;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check({tag, ".sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    cin      = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.sum", 32'(sum), 32'd0);
    check("reset.cout", 32'(cout), 32'd0);
    check("reset.invalid", 32'(invalid), 32'd0);
    step();

    // 1: basic add with partial sums 0000 -> 0002 -> 0012 -> 0912 -> 6912.
    do_op("t1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b1, {16'h0912, 16'h0012, 16'h0002, 16'h0000});

    // 2: carry ripples through every digit.
    do_op("t2a", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    do_op("t2b", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

    // 3: non-decimal digit flags invalid; cleared by the next accepted start.
    do_op("t3a", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    do_op("t3b", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    // Worst-case digit sum 15+15+1=31 -> digit 5, carry out.
    do_op("t3c", 16'h00FF, 16'h00FF, 1'b0, 16'h0154, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);

    // 4: start during busy and during DONE is ignored.
    do_op("t4", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    step();
    check("t4.no_second_done", 32'(done), 32'd0);
    check("t4.no_restart", 32'(busy), 32'd0);

    // 5: reset mid-operation aborts with no done pulse.
    a     = 16'h0123;
    b     = 16'h0456;
    cin   = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5.busy", 32'(busy), 32'd0);
    check("t5.sum", 32'(sum), 32'd0);
    check("t5.cout", 32'(cout), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("t5.no_done", 32'(done), 32'd0);
      check("t5.stay_idle", 32'(busy), 32'd0);
      step();
    end
    do_op("t5b", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

    // rst and start together: rst wins.
    a     = 16'h0001;
    b     = 16'h0001;
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start.busy", 32'(busy), 32'd0);
    step();
    check("rst_start.idle", 32'(busy), 32'd0);

    // 6: inputs scrambled while busy; result uses captured values, then holds.
    do_op("t6", 16'h4567, 16'h5555, 1'b1, 16'h0123, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    for (int k = 0; k < 10; k++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      step();
      check("t6.hold_sum", 32'(sum), 32'h0123);
      check("t6.hold_cout", 32'(cout), 32'd1);
      check("t6.hold_done", 32'(done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
